// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite scanline buffer.
//   SCREEN_W / V_VISIBLE / V_TOTAL : display geometry (pixels, lines)
//   PIXEL_W / pixel_t              : colour width and type
//   TRANSPARENT                    : colour key, also the cleared value
//   lb_state_t                     : line buffer control states
//   next_line()                    : vertical line increment with frame wrap
package sprite_pkg;

    localparam int SCREEN_W  = 640;
    localparam int V_VISIBLE = 480;
    localparam int V_TOTAL   = 525;
    localparam int PIXEL_W   = 16;
    localparam int COL_W     = 10;

    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam pixel_t TRANSPARENT = 16'h0000;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        FILL = 2'd2
    } lb_state_t;

    // Line following v; the last line of the frame wraps to line 0.
    function automatic logic [COL_W-1:0] next_line(input logic [COL_W-1:0] v,
                                                   input logic [COL_W-1:0] last_line);
        return (v == last_line) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/lb_bank.sv
// lb_bank: one scanline of pixel storage, simple dual-port.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, data registered one cycle after re
// No reset on the array or read register so the storage maps onto block RAM.
// Callers keep addresses below DEPTH.
module lb_bank #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: ping-pong scanline buffer between sprite_engine and the
// VGA pixel path. One bank is scanned out (and cleared behind the read) while
// the other collects the engine's pixel writes for the next line; the roles
// swap on every line_start.
//
// Ports:
//   clk, reset (async, active low)
//   line_start, vcount                 : VGA timing (end of visible line vcount)
//   sprite_start, sprite_vcount        : kick the engine for the line being filled
//   sprite_done                        : engine finished the line
//   wren_pixel_draw, sprite_pixel_col,
//   sprite_pixel_data                  : draw write port
//   rd_en, rd_col                      : display read request
//   pixel_out, pixel_valid             : display data, one cycle after rd_en
//   ready                              : power-up clear of both banks complete
//   overrun                            : sticky, engine missed a line deadline
//   overrun_count                      : only with SPRITE_LB_STATS_EN defined;
//                                        saturating count of overrun events
module sprite_line_buffer #(
    parameter int          SCREEN_W    = sprite_pkg::SCREEN_W,
    parameter int          V_VISIBLE   = sprite_pkg::V_VISIBLE,
    parameter int          V_TOTAL     = sprite_pkg::V_TOTAL,
    parameter logic [15:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [9:0]  vcount,
    output logic        sprite_start,
    output logic [9:0]  sprite_vcount,
    input  logic        sprite_done,
    input  logic        wren_pixel_draw,
    input  logic [9:0]  sprite_pixel_col,
    input  logic [15:0] sprite_pixel_data,
    input  logic        rd_en,
    input  logic [9:0]  rd_col,
    output logic [15:0] pixel_out,
    output logic        pixel_valid,
    output logic        ready,
    output logic        overrun
`ifdef SPRITE_LB_STATS_EN
    ,
    output logic [15:0] overrun_count
`endif
);

    import sprite_pkg::*;

    localparam logic [9:0] SCREEN_W_C  = 10'(SCREEN_W);
    localparam logic [9:0] LAST_COL    = 10'(SCREEN_W - 1);
    localparam logic [9:0] V_VISIBLE_C = 10'(V_VISIBLE);
    localparam logic [9:0] LAST_LINE   = 10'(V_TOTAL - 1);

    lb_state_t   state_q, state_d;
    logic [9:0]  init_col_q, init_col_d;
    logic        disp_sel_q, disp_sel_d;
    logic        sprite_start_q, sprite_start_d;
    logic [9:0]  sprite_vcount_q, sprite_vcount_d;
    logic        ready_q, ready_d;
    logic        overrun_q, overrun_d;
    // Read pipeline: which bank was read, and the pending clear-behind write.
    logic        rd_ok_q, rd_ok_d;
    logic        rd_bank_q, rd_bank_d;
    logic        clr_pend_q, clr_pend_d;
    logic [9:0]  clr_col_q, clr_col_d;
    logic        clr_bank_q, clr_bank_d;
`ifdef SPRITE_LB_STATS_EN
    logic [15:0] overrun_count_q, overrun_count_d;
`else
    // Statistics counter not built.
`endif

    logic [9:0]       target;
    logic             draw_we;
    logic             rd_hit;
    logic [1:0][15:0] bank_rdata;
    logic [15:0]      rd_data;

    assign target  = next_line(vcount, LAST_LINE);
    assign draw_we = (state_q == FILL) && wren_pixel_draw &&
                     (sprite_pixel_col < SCREEN_W_C) &&
                     (sprite_pixel_data != TRANSPARENT);
    assign rd_hit  = rd_en && (rd_col < SCREEN_W_C) && (state_q != INIT);

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d         = state_q;
        init_col_d      = init_col_q;
        disp_sel_d      = disp_sel_q;
        sprite_start_d  = 1'b0;
        sprite_vcount_d = sprite_vcount_q;
        ready_d         = ready_q;
        overrun_d       = overrun_q;
`ifdef SPRITE_LB_STATS_EN
        overrun_count_d = overrun_count_q;
`else
`endif
        case (state_q)
            INIT: begin
                init_col_d = init_col_q + 10'd1;
                if (init_col_q == LAST_COL) begin
                    init_col_d = '0;
                    state_d    = IDLE;
                    ready_d    = 1'b1;
                end
            end
            IDLE, FILL: begin
                if (line_start) begin
                    // A line boundary while still filling means the engine
                    // missed its deadline; a done in the same cycle made it.
                    if (state_q == FILL && !sprite_done) begin
                        overrun_d = 1'b1;
`ifdef SPRITE_LB_STATS_EN
                        if (overrun_count_q != 16'hFFFF) begin
                            overrun_count_d = overrun_count_q + 16'd1;
                        end
`else
`endif
                    end
                    disp_sel_d      = ~disp_sel_q;
                    sprite_vcount_d = target;
                    if (target < V_VISIBLE_C) begin
                        state_d        = FILL;
                        sprite_start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == FILL && sprite_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        rd_ok_d    = rd_hit;
        rd_bank_d  = disp_sel_q;
        clr_pend_d = rd_hit;
        clr_col_d  = rd_col;
        clr_bank_d = disp_sel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= INIT;
            init_col_q      <= '0;
            disp_sel_q      <= 1'b0;
            sprite_start_q  <= 1'b0;
            sprite_vcount_q <= '0;
            ready_q         <= 1'b0;
            overrun_q       <= 1'b0;
            rd_ok_q         <= 1'b0;
            rd_bank_q       <= 1'b0;
            clr_pend_q      <= 1'b0;
            clr_col_q       <= '0;
            clr_bank_q      <= 1'b0;
`ifdef SPRITE_LB_STATS_EN
            overrun_count_q <= '0;
`else
`endif
        end else begin
            state_q         <= state_d;
            init_col_q      <= init_col_d;
            disp_sel_q      <= disp_sel_d;
            sprite_start_q  <= sprite_start_d;
            sprite_vcount_q <= sprite_vcount_d;
            ready_q         <= ready_d;
            overrun_q       <= overrun_d;
            rd_ok_q         <= rd_ok_d;
            rd_bank_q       <= rd_bank_d;
            clr_pend_q      <= clr_pend_d;
            clr_col_q       <= clr_col_d;
            clr_bank_q      <= clr_bank_d;
`ifdef SPRITE_LB_STATS_EN
            overrun_count_q <= overrun_count_d;
`else
`endif
        end
    end

    // ------------------------------------------------------------------ banks
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic        we;
        logic [9:0]  waddr;
        logic [15:0] wdata;
        logic        is_disp;

        assign is_disp = (disp_sel_q == 1'(gi));

        // Write port arbitration. A clear-behind can only collide with a draw
        // write in the cycle right after a swap, when the just-read bank has
        // become the draw bank; the new pixel wins there.
        always_comb begin
            we    = 1'b0;
            waddr = '0;
            wdata = TRANSPARENT;
            if (state_q == INIT) begin
                we    = 1'b1;
                waddr = init_col_q;
            end else if (draw_we && !is_disp) begin
                we    = 1'b1;
                waddr = sprite_pixel_col;
                wdata = sprite_pixel_data;
            end else if (clr_pend_q && (clr_bank_q == 1'(gi))) begin
                we    = 1'b1;
                waddr = clr_col_q;
            end
        end

        lb_bank #(
            .DEPTH  (SCREEN_W),
            .ADDR_W (10),
            .DATA_W (16)
        ) u_bank (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .re    (rd_hit),
            .raddr (rd_col),
            .rdata (bank_rdata[gi])
        );
    end

    // ---------------------------------------------------------------- outputs
    // Out-of-range or INIT-time reads leave rd_ok_q low and show the key.
    assign rd_data       = rd_bank_q ? bank_rdata[1] : bank_rdata[0];
    assign pixel_out     = rd_ok_q ? rd_data : TRANSPARENT;
    assign pixel_valid   = (pixel_out != TRANSPARENT);
    assign sprite_start  = sprite_start_q;
    assign sprite_vcount = sprite_vcount_q;
    assign ready         = ready_q;
    assign overrun       = overrun_q;
`ifdef SPRITE_LB_STATS_EN
    assign overrun_count = overrun_count_q;
`else
`endif

endmodule

// File: tb/tb_sprite_line_buffer.sv
module tb_sprite_line_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  vcount = '0;
    logic        sprite_start;
    logic [9:0]  sprite_vcount;
    logic        sprite_done = 1'b0;
    logic        wren_pixel_draw = 1'b0;
    logic [9:0]  sprite_pixel_col = '0;
    logic [15:0] sprite_pixel_data = '0;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_col = '0;
    logic [15:0] pixel_out;
    logic        pixel_valid;
    logic        ready;
    logic        overrun;
`ifdef SPRITE_LB_STATS_EN
    logic [15:0] overrun_count;
`endif

    sprite_line_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .line_start        (line_start),
        .vcount            (vcount),
        .sprite_start      (sprite_start),
        .sprite_vcount     (sprite_vcount),
        .sprite_done       (sprite_done),
        .wren_pixel_draw   (wren_pixel_draw),
        .sprite_pixel_col  (sprite_pixel_col),
        .sprite_pixel_data (sprite_pixel_data),
        .rd_en             (rd_en),
        .rd_col            (rd_col),
        .pixel_out         (pixel_out),
        .pixel_valid       (pixel_valid),
        .ready             (ready),
        .overrun           (overrun)
`ifdef SPRITE_LB_STATS_EN
        ,
        .overrun_count     (overrun_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the line currently on screen and the line being drawn.
    logic [15:0] m_disp [0:639];
    logic [15:0] m_draw [0:639];
    bit          m_fill = 1'b0;
    bit          m_ovr = 1'b0;
    int          m_ovr_cnt = 0;

    task automatic model_clear_all();
        for (int i = 0; i < 640; i++) begin
            m_disp[i] = 16'h0000;
            m_draw[i] = 16'h0000;
        end
        m_fill    = 1'b0;
        m_ovr     = 1'b0;
        m_ovr_cnt = 0;
    endtask

    task automatic do_line_start(input logic [9:0] vc);
        logic [9:0]  tgt;
        logic        exp_start;
        logic [15:0] tmp;
        tgt       = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
        exp_start = (tgt < 10'd480);
        if (m_fill) begin
            m_ovr = 1'b1;
            m_ovr_cnt++;
        end
        for (int i = 0; i < 640; i++) begin
            tmp       = m_disp[i];
            m_disp[i] = m_draw[i];
            m_draw[i] = tmp;
        end
        m_fill = exp_start;
        line_start = 1'b1;
        vcount     = vc;
        @(negedge clk);
        line_start = 1'b0;
        n_cmp++;
        if (sprite_start !== exp_start) begin
            n_bad++;
            $display("FAIL sprite_start vcount=%0d: got %b expected %b", vc, sprite_start, exp_start);
        end
        n_cmp++;
        if (sprite_vcount !== tgt) begin
            n_bad++;
            $display("FAIL sprite_vcount vcount=%0d: got %0d expected %0d", vc, sprite_vcount, tgt);
        end
        n_cmp++;
        if (overrun !== m_ovr) begin
            n_bad++;
            $display("FAIL overrun vcount=%0d: got %b expected %b", vc, overrun, m_ovr);
        end
`ifdef SPRITE_LB_STATS_EN
        n_cmp++;
        if (overrun_count !== 16'(m_ovr_cnt)) begin
            n_bad++;
            $display("FAIL overrun_count: got %0d expected %0d", overrun_count, m_ovr_cnt);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (sprite_start !== 1'b0) begin
            n_bad++;
            $display("FAIL sprite_start_pulse_width vcount=%0d: got %b expected 0", vc, sprite_start);
        end
        $display("line_start vcount=%0d -> sprite_vcount=%0d start=%0b overrun=%0b", vc, tgt, exp_start, m_ovr);
    endtask

    task automatic write_px(input logic [9:0] col, input logic [15:0] data);
        wren_pixel_draw   = 1'b1;
        sprite_pixel_col  = col;
        sprite_pixel_data = data;
        @(negedge clk);
        wren_pixel_draw = 1'b0;
        if (m_fill && col < 10'd640 && data != 16'h0000) m_draw[col] = data;
        $display("write col=%0d data=%h", col, data);
    endtask

    task automatic done_pulse();
        sprite_done = 1'b1;
        @(negedge clk);
        sprite_done = 1'b0;
        m_fill = 1'b0;
    endtask

    // One read; back-to-back when called repeatedly since rd_en is
    // re-asserted at the same instant it is dropped.
    task automatic read_one(input logic [9:0] col, input string tag);
        logic [15:0] exp;
        exp = (col < 10'd640) ? m_disp[col] : 16'h0000;
        if (col < 10'd640) m_disp[col] = 16'h0000;
        rd_en  = 1'b1;
        rd_col = col;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++;
        if (pixel_out !== exp || pixel_valid !== (exp != 16'h0000)) begin
            n_bad++;
            $display("FAIL %s col=%0d: got %h/%b expected %h/%b", tag, col, pixel_out, pixel_valid, exp, exp != 16'h0000);
        end
    endtask

    task automatic scan(input string tag);
        for (int c = 0; c < 640; c++) read_one(10'(c), tag);
        $display("scan %s cols 0..639 complete", tag);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        line_start = 1'b0; sprite_done = 1'b0; wren_pixel_draw = 1'b0; rd_en = 1'b0;
        repeat (5) @(negedge clk);
        model_clear_all();
        n_cmp++;
        if (sprite_start !== 1'b0 || sprite_vcount !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_sprite: got %b/%0d expected 0/0", sprite_start, sprite_vcount);
        end
        n_cmp++;
        if (pixel_out !== 16'h0000 || pixel_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pixel: got %h/%b expected 0000/0", pixel_out, pixel_valid);
        end
        n_cmp++;
        if (ready !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ready=%b overrun=%b expected 0/0", ready, overrun);
        end
`ifdef SPRITE_LB_STATS_EN
        n_cmp++;
        if (overrun_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_overrun_count: got %0d expected 0", overrun_count);
        end
`endif
        reset = 1'b1;
        for (int k = 1; k <= 640; k++) begin
            @(negedge clk);
            if (k == 639) begin
                n_cmp++;
                if (ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ready_early: got %b expected 0 after 639 cycles", ready);
                end
            end
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_rise: got %b expected 1 after 640 cycles", ready);
        end
        $display("reset released, ready=%b", ready);
    endtask

    task automatic test_init_clear();
        scan("init_bank0");
        do_line_start(10'd479);
        scan("init_bank1");
    endtask

    task automatic test_fill_display();
        do_line_start(10'd9);
        write_px(10'd100, 16'hF800);
        write_px(10'd639, 16'h07E0);
        done_pulse();
        do_line_start(10'd10);
        done_pulse();
        read_one(10'd99, "fill_neighbour");
        read_one(10'd100, "fill_col100");
        read_one(10'd639, "fill_col639");
        scan("fill_display");
    endtask

    task automatic test_clear_after_read();
        // Scan of line 11 already cleared col 100; it must stay empty.
        do_line_start(10'd11);
        done_pulse();
        do_line_start(10'd12);
        done_pulse();
        read_one(10'd100, "clear_after_read");
        scan("clear_after_read_flush");
    endtask

    task automatic test_filter();
        do_line_start(10'd20);
        write_px(10'd5, 16'h001F);
        write_px(10'd640, 16'hAAAA);
        write_px(10'd1023, 16'hBBBB);
        write_px(10'd5, 16'h0000);
        write_px(10'd7, 16'h1111);
        write_px(10'd7, 16'h2222);
        done_pulse();
        do_line_start(10'd21);
        done_pulse();
        read_one(10'd5, "filter_col5");
        read_one(10'd7, "filter_col7_last_writer");
        read_one(10'd640, "filter_rd_640");
        read_one(10'd1023, "filter_rd_1023");
        scan("filter_flush");
    endtask

    task automatic test_wrap();
        do_line_start(10'd524);
        done_pulse();
        do_line_start(10'd479);
        scan("wrap_flush");
    endtask

    task automatic test_random();
        logic [9:0]  vc;
        logic [9:0]  col;
        logic [15:0] data;
        int          nw;
        for (int ln = 0; ln < 4; ln++) begin
            vc = 10'($urandom_range(0, 470));
            do_line_start(vc);
            nw = $urandom_range(10, 40);
            for (int w = 0; w < nw; w++) begin
                case ($urandom_range(0, 3))
                    0:       col = 10'($urandom_range(640, 1023));
                    1:       col = 10'($urandom_range(0, 15));
                    default: col = 10'($urandom_range(0, 639));
                endcase
                data = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
                write_px(col, data);
            end
            done_pulse();
            do_line_start(vc + 10'd1);
            done_pulse();
            for (int r = 0; r < 20; r++) read_one(10'($urandom_range(0, 1023)), "random_read");
            scan("random_flush");
        end
    endtask

    task automatic test_overrun();
        do_line_start(10'd30);
        write_px(10'd3, 16'h1234);
        // No sprite_done: this line_start lands during FILL.
        do_line_start(10'd31);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        done_pulse();
        read_one(10'd3, "overrun_partial_line");
        scan("overrun_flush");
    endtask

    task automatic test_mid_reset();
        do_line_start(10'd40);
        write_px(10'd8, 16'h5555);
        done_pulse();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b0 || ready !== 1'b0 || sprite_vcount !== 10'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got overrun=%b ready=%b vcount=%0d expected 0/0/0", overrun, ready, sprite_vcount);
        end
        model_clear_all();
        reset = 1'b1;
        repeat (640) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_ready: got %b expected 1", ready);
        end
        scan("mid_reset_bank_a");
        do_line_start(10'd479);
        scan("mid_reset_bank_b");
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_fill_display();
        test_clear_after_read();
        test_filter();
        test_wrap();
        test_random();
        test_overrun();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
